// File: rtl/fog_pkg.sv
// rtl/fog_pkg.sv - shared widths, types and shift clamp for the FOG rate decimator
package fog_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ACC_W     = 48;
  localparam int DEF_MAX_SHIFT = 10;

  typedef enum logic {IDLE, ACC} state_t;

  typedef logic signed [DEF_DATA_W-1:0] step_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

  function automatic int unsigned clamp_shift(input logic [31:0] sel, input int unsigned max_shift);
    return (sel > max_shift) ? max_shift : sel;
  endfunction

endpackage

// File: rtl/fog_boxcar_acc.sv
// rtl/fog_boxcar_acc.sv - one boxcar channel: block sum, sample count and latched shift
module fog_boxcar_acc
  import fog_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              add,
  input  logic [31:0]       dec_sel,
  input  logic [DATA_W-1:0] sample,
  output logic              last,
  output logic [DATA_W-1:0] avg
);

  localparam int SHIFT_W = $clog2(MAX_SHIFT + 1);
  localparam int CNT_W   = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;
  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sample_x;
  logic signed [ACC_W-1:0] total;
  logic [CNT_W-1:0]        cnt;
  logic [SHIFT_W-1:0]      shift;

  assign sample_x = {{(ACC_W-DATA_W){sample[DATA_W-1]}}, sample};
  assign total    = sum + sample_x;
  // The closing sample is folded in combinationally so the mean lands on the same edge.
  assign avg      = DATA_W'(total >>> shift);
  assign last     = ({1'b0, cnt} == ((ONE << shift) - ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      cnt   <= '0;
      shift <= '0;
    end else if (load || (add && last)) begin
      sum   <= '0;
      cnt   <= '0;
      shift <= SHIFT_W'(clamp_shift(dec_sel, MAX_SHIFT));
    end else if (add) begin
      sum   <= total;
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fog_rate_decimator.sv
// rtl/fog_rate_decimator.sv - decimated rate/error snapshots, angle integrator and sequence counter
module fog_rate_decimator
  import fog_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_trig,
  input  logic [DATA_W-1:0] i_step,
  input  logic [DATA_W-1:0] i_err,
  input  logic [31:0]       i_dec_sel,
  input  logic              i_angle_clr,
  input  logic              i_rd_ack,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_rate,
  output logic [DATA_W-1:0] o_err_avg,
  output logic [ACC_W-1:0]  o_angle,
  output logic [15:0]       o_seq,
  output logic              o_overrun
);

  state_t            state;
  logic              load;
  logic              add;
  logic              close;
  logic              last_s;
  logic              last_e;
  logic [DATA_W-1:0] avg_s;
  logic [DATA_W-1:0] avg_e;
  logic [ACC_W-1:0]  step_x;

  assign load   = (state == IDLE) && i_en;
  assign add    = (state == ACC) && i_en && i_trig;
  assign close  = add && last_s && last_e;
  assign step_x = {{(ACC_W-DATA_W){i_step[DATA_W-1]}}, i_step};

  fog_boxcar_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_SHIFT(MAX_SHIFT)) u_step_acc (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (load),
    .add     (add),
    .dec_sel (i_dec_sel),
    .sample  (i_step),
    .last    (last_s),
    .avg     (avg_s)
  );

  fog_boxcar_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_SHIFT(MAX_SHIFT)) u_err_acc (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (load),
    .add     (add),
    .dec_sel (i_dec_sel),
    .sample  (i_err),
    .last    (last_e),
    .avg     (avg_e)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      o_valid   <= 1'b0;
      o_rate    <= '0;
      o_err_avg <= '0;
      o_angle   <= '0;
      o_seq     <= '0;
      o_overrun <= 1'b0;
    end else begin
      state <= i_en ? ACC : IDLE;

      if (close) begin
        o_rate    <= avg_s;
        o_err_avg <= avg_e;
        o_seq     <= o_seq + 16'd1;
        o_valid   <= 1'b1;
        // A coinciding ack consumed the old snapshot, so nothing was lost.
        o_overrun <= i_rd_ack ? 1'b0 : (o_overrun | o_valid);
      end else if (i_rd_ack && o_valid) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end

      if (i_angle_clr) begin
        o_angle <= '0;
      end else if (i_trig) begin
        o_angle <= o_angle + step_x;
      end
    end
  end

endmodule

// File: tb/tb_fog_rate_decimator.sv
// tb/tb_fog_rate_decimator.sv - directed and randomized checks against a block-mean reference model
module tb_fog_rate_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        trig;
  logic [31:0] step;
  logic [31:0] err;
  logic [31:0] dec_sel;
  logic        clr;
  logic        ack;

  logic        valid;
  logic [31:0] rate;
  logic [31:0] err_avg;
  logic [47:0] angle;
  logic [15:0] seq;
  logic        overrun;

  fog_rate_decimator dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_trig      (trig),
    .i_step      (step),
    .i_err       (err),
    .i_dec_sel   (dec_sel),
    .i_angle_clr (clr),
    .i_rd_ack    (ack),
    .o_valid     (valid),
    .o_rate      (rate),
    .o_err_avg   (err_avg),
    .o_angle     (angle),
    .o_seq       (seq),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b1;

  // Reference model: a block is the list of samples taken since the last close.
  bit          m_active;
  int          m_shift;
  int          q_s[$];
  int          q_e[$];
  bit          m_valid;
  bit          m_over;
  logic [31:0] m_rate;
  logic [31:0] m_err;
  logic [15:0] m_seq;
  logic [47:0] m_angle;
  logic [15:0] saved_seq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int clamp(input logic [31:0] s);
    return (s > 32'd10) ? 10 : int'(s);
  endfunction

  // Floor of the block mean, computed by division rather than shifting.
  function automatic logic [31:0] block_mean(input int q[$], input int sh);
    longint s = 0;
    longint n = longint'(1) << sh;
    longint m;
    foreach (q[i]) s += longint'(q[i]);
    m = s / n;
    if ((s % n != 0) && (s < 0)) m -= 1;
    return m[31:0];
  endfunction

  task automatic model_edge();
    bit closing = 1'b0;
    if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_shift  = clamp(dec_sel);
        q_s.delete();
        q_e.delete();
      end
    end else if (!en) begin
      m_active = 1'b0;
    end else if (trig) begin
      q_s.push_back($signed(step));
      q_e.push_back($signed(err));
      if (q_s.size() == (1 << m_shift)) begin
        closing = 1'b1;
        m_rate  = block_mean(q_s, m_shift);
        m_err   = block_mean(q_e, m_shift);
        q_s.delete();
        q_e.delete();
        m_shift = clamp(dec_sel);
      end
    end
    if (closing) begin
      m_seq++;
      if (ack) m_over = 1'b0;
      else if (m_valid) m_over = 1'b1;
      m_valid = 1'b1;
    end else if (ack && m_valid) begin
      m_valid = 1'b0;
      m_over  = 1'b0;
    end
    if (clr) m_angle = '0;
    else if (trig) m_angle = m_angle + {{16{step[31]}}, step};
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (cmp_on) begin
      chk("valid",   64'(valid),   64'(m_valid));
      chk("rate",    64'(rate),    64'(m_rate));
      chk("err_avg", 64'(err_avg), 64'(m_err));
      chk("angle",   64'(angle),   64'(m_angle));
      chk("seq",     64'(seq),     64'(m_seq));
      chk("overrun", 64'(overrun), 64'(m_over));
    end
  endtask

  task automatic trig_cycle(input logic [31:0] s, input logic [31:0] e);
    trig = 1'b1;
    step = s;
    err  = e;
    tick();
    trig = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; trig = 1'b0; step = '0; err = '0;
    dec_sel = '0; clr = 1'b0; ack = 1'b0;
    m_active = 1'b0; m_shift = 0; m_valid = 1'b0; m_over = 1'b0;
    m_rate = '0; m_err = '0; m_seq = '0; m_angle = '0;

    // Reset held while triggers toggle
    repeat (6) begin
      @(negedge clk);
      trig = ~trig;
      step = $urandom;
    end
    @(negedge clk);
    trig  = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_valid",   64'(valid),   64'd0);
    chk("rst_rate",    64'(rate),    64'd0);
    chk("rst_err",     64'(err_avg), 64'd0);
    chk("rst_angle",   64'(angle),   64'd0);
    chk("rst_seq",     64'(seq),     64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);

    // Four-sample block
    en = 1'b1; dec_sel = 32'd2;
    tick();
    trig_cycle(32'd10, 32'hFFFF_FFFC);
    trig_cycle(32'd20, 32'hFFFF_FFFC);
    trig_cycle(32'd30, 32'hFFFF_FFFC);
    trig_cycle(32'd41, 32'hFFFF_FFFC);
    chk("blk4_rate",  64'(rate),    64'd25);
    chk("blk4_err",   64'(err_avg), 64'(32'hFFFF_FFFC));
    chk("blk4_seq",   64'(seq),     64'd1);
    chk("blk4_valid", 64'(valid),   64'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_valid", 64'(valid), 64'd0);

    // N=1, overrun, then ack coincident with closure
    en = 1'b0; tick();
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; dec_sel = 32'd0; tick();
    trig_cycle(32'hFFFF_FFF9, 32'd3);
    chk("n1_rate",  64'(rate),  64'(32'hFFFF_FFF9));
    chk("n1_seq",   64'(seq),   64'd2);
    trig_cycle(32'hFFFF_FFF9, 32'd3);
    chk("ovr_set",  64'(overrun), 64'd1);
    chk("ovr_seq",  64'(seq),     64'd3);
    ack = 1'b1;
    trig_cycle(32'hFFFF_FFF9, 32'd3);
    ack = 1'b0;
    chk("coin_valid",   64'(valid),   64'd1);
    chk("coin_overrun", 64'(overrun), 64'd0);
    chk("n1_angle",     64'(angle),   64'(48'hFFFF_FFFF_FFEB));
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack2_valid", 64'(valid), 64'd0);

    // Mid-block dec_sel change applies at the next boundary
    en = 1'b0; tick();
    en = 1'b1; dec_sel = 32'd1; tick();
    trig_cycle(32'd5, 32'd5);
    dec_sel = 32'd3;
    trig_cycle(32'd7, 32'd7);
    chk("sel_close2", 64'(valid), 64'd1);
    chk("sel_rate",   64'(rate),  64'd6);
    ack = 1'b1; tick(); ack = 1'b0;
    repeat (7) trig_cycle($urandom, $urandom);
    chk("sel_open7",  64'(valid), 64'd0);
    trig_cycle($urandom, $urandom);
    chk("sel_close8", 64'(valid), 64'd1);
    ack = 1'b1; tick(); ack = 1'b0;

    // Oversized dec_sel clamps to 1024 samples
    en = 1'b0; tick();
    en = 1'b1; dec_sel = 32'd50; tick();
    repeat (1023) trig_cycle($urandom, $urandom);
    chk("clamp_open",  64'(valid), 64'd0);
    trig_cycle($urandom, $urandom);
    chk("clamp_close", 64'(valid), 64'd1);
    ack = 1'b1; tick(); ack = 1'b0;

    // Angle wrap at 48 bits, preloaded to 2^47-1 while idle
    en = 1'b0; dec_sel = 32'd2;
    clr = 1'b1; tick(); clr = 1'b0;
    cmp_on = 1'b0;
    trig = 1'b1; step = 32'h7FFF_FFFF;
    repeat (65536) tick();
    step = 32'd65535; tick();
    trig = 1'b0;
    cmp_on = 1'b1;
    chk("wrap_pre",  64'(angle), 64'(48'h7FFF_FFFF_FFFF));
    trig_cycle(32'd1, 32'd0);
    chk("wrap_post", 64'(angle), 64'(48'h8000_0000_0000));

    clr = 1'b1;
    trig_cycle(32'd123, 32'd0);
    clr = 1'b0;
    chk("clr_prio", 64'(angle), 64'd0);

    // Enable drop mid-block discards the partial block
    saved_seq = m_seq;
    en = 1'b1; dec_sel = 32'd2; tick();
    trig_cycle(32'd1, 32'd1);
    trig_cycle(32'd2, 32'd2);
    en = 1'b0;
    trig_cycle(32'd100, 32'd0);
    chk("drop_seq",   64'(seq),   64'(saved_seq));
    chk("drop_valid", 64'(valid), 64'd0);
    chk("drop_angle", 64'(angle), 64'd103);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      en      = ($urandom_range(0, 39) != 0);
      trig    = $urandom_range(0, 1);
      step    = $urandom;
      err     = $urandom;
      dec_sel = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 3);
      ack     = ($urandom_range(0, 4) == 0);
      clr     = ($urandom_range(0, 49) == 0);
      tick();
    end
    trig = 1'b0; ack = 1'b0; clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
